// File: rtl/serial_adder_pkg.sv
// serial_adder_pkg: shared types and helpers for the bit-serial adder.
//   state_e   - FSM state encoding (IDLE, RUN, DONE), 2 bits
//   cnt_width - width of the bit counter for a given operand width
package serial_adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // The counter must be able to hold WIDTH itself, hence WIDTH+1.
  function automatic int cnt_width(input int width);
    return $clog2(width + 1);
  endfunction

  localparam int MAX_WIDTH = 32;
  localparam int MAX_CNT_W = cnt_width(MAX_WIDTH);

endpackage

// File: rtl/serial_adder_if.sv
// serial_adder_if: request/result bundle of the bit-serial adder.
//   i_start, i_a, i_b, i_cin : request side (driven by the master)
//   o_busy, o_done           : status (driven by the adder)
//   o_s, o_cout, o_ovf       : result (driven by the adder)
interface serial_adder_if #(
  parameter int WIDTH = 8
) ();

  logic             i_start;
  logic [WIDTH-1:0] i_a;
  logic [WIDTH-1:0] i_b;
  logic             i_cin;
  logic             o_busy;
  logic             o_done;
  logic [WIDTH-1:0] o_s;
  logic             o_cout;
  logic             o_ovf;

  modport master (
    output i_start, i_a, i_b, i_cin,
    input  o_busy, o_done, o_s, o_cout, o_ovf
  );

  modport slave (
    input  i_start, i_a, i_b, i_cin,
    output o_busy, o_done, o_s, o_cout, o_ovf
  );

endinterface

// File: rtl/and_gate.sv
// and_gate: two-input AND primitive.
//   i_a, i_b : inputs
//   o_y      : i_a & i_b
module and_gate (
  input  logic i_a,
  input  logic i_b,
  output logic o_y
);
  assign o_y = i_a & i_b;
endmodule

// File: rtl/full_adder.sv
// full_adder: one-bit full adder built from gate primitives.
//   i_a, i_b, i_cin : addend bits and carry-in
//   o_s             : i_a ^ i_b ^ i_cin
//   o_cout          : (i_a & i_b) | (i_cin & (i_a ^ i_b))
module full_adder (
  input  logic i_a,
  input  logic i_b,
  input  logic i_cin,
  output logic o_s,
  output logic o_cout
);

  logic w_axb;
  logic w_ab;
  logic w_cxab;

  xor_gate u_xor_ab  (.i_a(i_a),   .i_b(i_b),   .o_y(w_axb));
  xor_gate u_xor_sum (.i_a(w_axb), .i_b(i_cin), .o_y(o_s));
  and_gate u_and_ab  (.i_a(i_a),   .i_b(i_b),   .o_y(w_ab));
  // Propagate term: carry passes through when exactly one operand bit is set.
  and_gate u_and_prp (.i_a(i_cin), .i_b(w_axb), .o_y(w_cxab));
  or_gate  u_or_cout (.i_a(w_ab),  .i_b(w_cxab), .o_y(o_cout));

endmodule

// File: rtl/or_gate.sv
// or_gate: two-input OR primitive.
//   i_a, i_b : inputs
//   o_y      : i_a | i_b
module or_gate (
  input  logic i_a,
  input  logic i_b,
  output logic o_y
);
  assign o_y = i_a | i_b;
endmodule

// File: rtl/xor_gate.sv
// xor_gate: two-input XOR primitive.
//   i_a, i_b : inputs
//   o_y      : i_a ^ i_b
module xor_gate (
  input  logic i_a,
  input  logic i_b,
  output logic o_y
);
  assign o_y = i_a ^ i_b;
endmodule

// File: rtl/serial_adder.sv
// serial_adder: bit-serial two's-complement adder, LSB first, one full-adder
// cell reused every cycle. Result s = a + b + cin (mod 2^WIDTH).
//   i_clk : rising-edge clock
//   i_rst : synchronous reset, active-high
//   bus   : serial_adder_if.slave
//           i_start/i_a/i_b/i_cin request, o_busy/o_done status,
//           o_s/o_cout/o_ovf result (valid from o_done, held until next accept)
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic          i_clk,
  input  logic          i_rst,
  serial_adder_if.slave bus
);

  localparam int CW = cnt_width(WIDTH);

  state_e           r_state;
  state_e           w_next_state;
  logic [WIDTH-1:0] r_ra;
  logic [WIDTH-1:0] r_rb;
  logic [WIDTH-1:0] r_s;
  logic [WIDTH-1:0] w_s_next;
  logic             r_rc;
  logic [CW-1:0]    r_cnt;
  logic             r_cout;
  logic             r_ovf;
  logic             r_busy;
  logic             r_done;
  logic             w_fa_s;
  logic             w_fa_cout;
  logic             w_last;

  full_adder u_fa (
    .i_a    (r_ra[0]),
    .i_b    (r_rb[0]),
    .i_cin  (r_rc),
    .o_s    (w_fa_s),
    .o_cout (w_fa_cout)
  );

  assign w_last = (r_cnt == CW'(WIDTH - 1));

  // New sum bit enters at the MSB; after WIDTH shifts bit 0 lands at s[0].
  generate
    if (WIDTH == 1) begin : g_s_w1
      assign w_s_next = w_fa_s;
    end else begin : g_s_wn
      assign w_s_next = {w_fa_s, r_s[WIDTH-1:1]};
    end
  endgenerate

  // State register
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE: begin
        if (bus.i_start) begin
          w_next_state = RUN;
        end else begin
          w_next_state = IDLE;
        end
      end
      RUN: begin
        if (w_last) begin
          w_next_state = DONE;
        end else begin
          w_next_state = RUN;
        end
      end
      DONE:    w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  // Datapath: operand shift registers, carry, counter and result registers
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_ra   <= {WIDTH{1'b0}};
      r_rb   <= {WIDTH{1'b0}};
      r_s    <= {WIDTH{1'b0}};
      r_rc   <= 1'b0;
      r_cnt  <= {CW{1'b0}};
      r_cout <= 1'b0;
      r_ovf  <= 1'b0;
      r_busy <= 1'b0;
      r_done <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          r_done <= 1'b0;
          if (bus.i_start) begin
            r_ra   <= bus.i_a;
            r_rb   <= bus.i_b;
            r_rc   <= bus.i_cin;
            r_cnt  <= {CW{1'b0}};
            r_s    <= {WIDTH{1'b0}};
            r_busy <= 1'b1;
          end else begin
            r_busy <= 1'b0;
          end
        end
        RUN: begin
          r_ra  <= r_ra >> 1;
          r_rb  <= r_rb >> 1;
          r_s   <= w_s_next;
          r_rc  <= w_fa_cout;
          r_cnt <= r_cnt + CW'(1);
          if (w_last) begin
            r_cout <= w_fa_cout;
            // r_rc here is the carry into the MSB.
            r_ovf  <= r_rc ^ w_fa_cout;
            r_busy <= 1'b0;
            r_done <= 1'b1;
          end else begin
            r_busy <= 1'b1;
            r_done <= 1'b0;
          end
        end
        DONE: begin
          r_busy <= 1'b0;
          r_done <= 1'b0;
        end
        default: begin
          r_busy <= 1'b0;
          r_done <= 1'b0;
        end
      endcase
    end
  end

  assign bus.o_busy = r_busy;
  assign bus.o_done = r_done;
  assign bus.o_s    = r_s;
  assign bus.o_cout = r_cout;
  assign bus.o_ovf  = r_ovf;

endmodule

// File: tb/tb_serial_adder.sv
// tb_serial_adder: directed self-checking bench for serial_adder (WIDTH=8).
module tb_serial_adder;

  localparam int W = 8;

  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_fails  = 0;

  serial_adder_if #(.WIDTH(W)) bus ();

  serial_adder #(.WIDTH(W)) u_dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference: {ovf, cout, s[7:0]} using the sign rule for overflow.
  function automatic logic [9:0] model_add(input logic [7:0] a, input logic [7:0] b, input logic cin);
    logic [8:0] full;
    logic       ovf;
    full = {1'b0, a} + {1'b0, b} + {8'd0, cin};
    ovf  = (a[7] == b[7]) && (full[7] != a[7]);
    return {ovf, full};
  endfunction

  // One operation; optional extra start pulse in RUN cycle pulse_k.
  task automatic run_op(input string tag, input logic [7:0] a, input logic [7:0] b, input logic cin,
                        input logic [7:0] es, input logic ec, input logic eo, input int pulse_k);
    int   lat   = 0;
    int   nbusy = 0;
    logic both  = 1'b0;
    @(negedge clk);
    bus.i_start = 1'b1;
    bus.i_a     = a;
    bus.i_b     = b;
    bus.i_cin   = cin;
    @(posedge clk);
    #1 bus.i_start = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (bus.o_busy && bus.o_done) both = 1'b1;
      if (bus.o_busy) nbusy++;
      if (bus.o_done) begin
        lat = k;
        break;
      end
      if (k == pulse_k) begin
        bus.i_start = 1'b1;
        bus.i_a     = 8'h01;
        bus.i_b     = 8'h01;
        bus.i_cin   = 1'b0;
      end else begin
        bus.i_start = 1'b0;
      end
    end
    bus.i_start = 1'b0;
    check({tag, "_latency"}, 32'(lat), 32'd9);
    check({tag, "_busy_cycles"}, 32'(nbusy), 32'd8);
    check({tag, "_busy_and_done"}, 32'(both), 32'd0);
    check({tag, "_s"}, 32'(bus.o_s), 32'(es));
    check({tag, "_cout"}, 32'(bus.o_cout), 32'(ec));
    check({tag, "_ovf"}, 32'(bus.o_ovf), 32'(eo));
  endtask

  initial begin
    logic [9:0] exp_arr [0:4];
    logic [7:0] ra;
    logic [7:0] rb;
    logic [7:0] es;
    int         dcount;
    int         diff;
    int         kk;

    rst         = 1'b1;
    bus.i_start = 1'b0;
    bus.i_a     = 8'h00;
    bus.i_b     = 8'h00;
    bus.i_cin   = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_busy", 32'(bus.o_busy), 32'd0);
    check("rst_done", 32'(bus.o_done), 32'd0);
    check("rst_s",    32'(bus.o_s),    32'd0);
    check("rst_cout", 32'(bus.o_cout), 32'd0);
    check("rst_ovf",  32'(bus.o_ovf),  32'd0);
    rst = 1'b0;

    // Directed vectors with hand-computed results.
    run_op("add_5a_33", 8'h5A, 8'h33, 1'b0, 8'h8D, 1'b0, 1'b1, 0);
    run_op("add_ff_01", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0, 0);
    run_op("add_80_80", 8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1, 0);
    run_op("sub_10_03", 8'h10, 8'hFC, 1'b1, 8'h0D, 1'b1, 1'b0, 0);
    run_op("add_00_00_c", 8'h00, 8'h00, 1'b1, 8'h01, 1'b0, 1'b0, 0);
    run_op("add_7f_00_c", 8'h7F, 8'h00, 1'b1, 8'h80, 1'b0, 1'b1, 0);

    // Start pulse in RUN cycle 3 is ignored.
    run_op("start_in_run", 8'h5A, 8'h33, 1'b0, 8'h8D, 1'b0, 1'b1, 3);
    @(negedge clk);
    check("start_in_run_no_restart", 32'(bus.o_busy), 32'd0);

    // Subtraction sweep: a + ~b + 1 against a - b.
    for (int n = 0; n < 256; n++) begin
      ra   = 8'($urandom_range(0, 255));
      rb   = 8'($urandom_range(0, 255));
      es   = 8'(int'(ra) - int'(rb));
      diff = int'($signed(ra)) - int'($signed(rb));
      run_op("sweep_sub", ra, ~rb, 1'b1, es, (ra >= rb),
             ((diff > 127) || (diff < -128)), 0);
    end

    // Reset in RUN cycle 4 aborts without a done strobe.
    @(negedge clk);
    bus.i_start = 1'b1;
    bus.i_a     = 8'h5A;
    bus.i_b     = 8'h33;
    bus.i_cin   = 1'b0;
    @(posedge clk);
    #1 bus.i_start = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst_busy", 32'(bus.o_busy), 32'd0);
    check("midrst_done", 32'(bus.o_done), 32'd0);
    check("midrst_s",    32'(bus.o_s),    32'd0);
    check("midrst_cout", 32'(bus.o_cout), 32'd0);
    check("midrst_ovf",  32'(bus.o_ovf),  32'd0);
    dcount = 0;
    for (int k = 0; k < 15; k++) begin
      @(negedge clk);
      if (bus.o_done) dcount++;
    end
    check("midrst_no_done", 32'(dcount), 32'd0);
    run_op("after_rst", 8'h10, 8'hFC, 1'b1, 8'h0D, 1'b1, 1'b0, 0);

    // Held start with operands changing every cycle: accepts every 10 cycles.
    @(negedge clk);
    for (int i = 0; i <= 40; i++) begin
      if ((i >= 9) && (i % 10 == 9)) begin
        kk = (i - 9) / 10;
        check("held_done",   32'(bus.o_done), 32'd1);
        check("held_s",      32'(bus.o_s),    32'(exp_arr[kk][7:0]));
        check("held_cout",   32'(bus.o_cout), 32'(exp_arr[kk][8]));
        check("held_ovf",    32'(bus.o_ovf),  32'(exp_arr[kk][9]));
      end else if ((i >= 10) && (i % 10 == 0)) begin
        kk = (i - 10) / 10;
        check("held_done_low",  32'(bus.o_done), 32'd0);
        check("held_s_stable",  32'(bus.o_s),    32'(exp_arr[kk][7:0]));
        check("held_cout_stab", 32'(bus.o_cout), 32'(exp_arr[kk][8]));
        check("held_ovf_stab",  32'(bus.o_ovf),  32'(exp_arr[kk][9]));
      end
      bus.i_a   = 8'(i * 37 + 5);
      bus.i_b   = 8'(i * 11 + 200);
      bus.i_cin = 1'(i % 2);
      if (i % 10 == 0) begin
        exp_arr[i / 10] = model_add(bus.i_a, bus.i_b, bus.i_cin);
      end
      if (i < 40) begin
        bus.i_start = 1'b1;
      end else begin
        bus.i_start = 1'b0;
      end
      @(negedge clk);
    end
    check("held_end_idle", 32'(bus.o_busy), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fails);
    $finish;
  end

endmodule
